// File: rtl/systolic_row_pkg.sv
// Shared definitions for the systolic MAC row: default widths, controller
// states and the signed-add overflow test used by every element.
package systolic_row_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefAccW  = 24;
    localparam int unsigned DefNPe   = 4;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StFlush = 2'd1,
        StDrain = 2'd2
    } row_state_e;

    // Two's-complement add overflowed: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic sign_a, input logic sign_b,
                                     input logic sign_sum);
        return (sign_a == sign_b) && (sign_sum != sign_a);
    endfunction

endpackage

// File: rtl/systolic_row_if.sv
// Operand, readout and pass-through signals of one systolic row.
interface systolic_row_if
    import systolic_row_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ACC_W  = DefAccW,
    parameter int unsigned N_PE   = DefNPe
);
    logic                     clear_in;
    logic                     a_valid_in;
    logic [DATA_W-1:0]        a_in;
    logic [N_PE*DATA_W-1:0]   b_in;
    logic                     drain_in;
    logic                     ready_out;
    logic [DATA_W-1:0]        a_out;
    logic                     a_valid_out;
    logic [N_PE*DATA_W-1:0]   b_out;
    logic [ACC_W-1:0]         c_out;
    logic                     c_valid_out;
    logic                     ovf_out;

    modport master (
        output clear_in, a_valid_in, a_in, b_in, drain_in,
        input  ready_out, a_out, a_valid_out, b_out, c_out, c_valid_out, ovf_out
    );

    modport slave (
        input  clear_in, a_valid_in, a_in, b_in, drain_in,
        output ready_out, a_out, a_valid_out, b_out, c_out, c_valid_out, ovf_out
    );

endinterface

// File: rtl/systolic_pe.sv
// One output-stationary MAC element: registers the passing operand, accumulates
// a*b, and doubles as a stage of the accumulator readout shift chain.
module systolic_pe
    import systolic_row_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ACC_W  = DefAccW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_valid_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_valid_out,
    input  logic [DATA_W-1:0] b_in,
    input  logic              clear_in,
    input  logic              kill_in,    // clear outside RUN: also drop in-flight samples
    input  logic              shift_en,
    input  logic [ACC_W-1:0]  shift_in,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf_out
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic [ACC_W-1:0]           sum;
    logic                       acc_en;
    logic [DATA_W-1:0]          a_q;
    logic                       a_valid_q;
    logic [ACC_W-1:0]           acc_q, acc_d;
    logic                       ovf_q, ovf_d;

    assign prod     = $signed(a_in) * $signed(b_in);
    assign prod_ext = ACC_W'(prod);
    assign acc_en   = a_valid_in & ~kill_in;
    assign sum      = acc_q + prod_ext;

    // Accumulator next value: clear beats shift beats accumulate.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clear_in) begin
            acc_d = acc_en ? prod_ext : '0;
            ovf_d = 1'b0;
        end else if (shift_en) begin
            acc_d = shift_in;
        end else if (acc_en) begin
            acc_d = sum;
            if (add_ovf(acc_q[ACC_W-1], prod_ext[ACC_W-1], sum[ACC_W-1])) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Operand pipeline register and accumulator state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q       <= '0;
            a_valid_q <= 1'b0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            a_valid_q <= acc_en;
            if (acc_en) begin
                a_q <= a_in;
            end
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign a_out       = a_q;
    assign a_valid_out = a_valid_q;
    assign acc_out     = acc_q;
    assign ovf_out     = ovf_q;

endmodule

// File: rtl/systolic_row.sv
// One-dimensional output-stationary systolic row. Operand a ripples through the
// elements; accumulators are flushed and then read out serially, last element first.
module systolic_row
    import systolic_row_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ACC_W  = DefAccW,
    parameter int unsigned N_PE   = DefNPe
) (
    input logic           clock,
    input logic           reset,
    systolic_row_if.slave bus
);

    localparam int unsigned CntW = (N_PE > 1) ? $clog2(N_PE) : 1;

    row_state_e               state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [N_PE*DATA_W-1:0]   b_q;
    logic [N_PE:0][DATA_W-1:0] a_chain;
    logic [N_PE:0]            v_chain;
    logic [N_PE:0][ACC_W-1:0] acc_chain;
    logic [N_PE-1:0]          pe_ovf;
    logic                     ready, accept, kill, shift_en;

    assign ready        = (state_q == StRun);
    assign accept       = bus.a_valid_in & ready;
    assign kill         = bus.clear_in & ~ready;
    assign a_chain[0]   = bus.a_in;
    assign v_chain[0]   = accept;
    assign acc_chain[0] = '0;

    for (genvar k = 0; k < N_PE; k++) begin : g_pe
        systolic_pe #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_pe (
            .clock       (clock),
            .reset       (reset),
            .a_in        (a_chain[k]),
            .a_valid_in  (v_chain[k]),
            .a_out       (a_chain[k+1]),
            .a_valid_out (v_chain[k+1]),
            .b_in        (bus.b_in[k*DATA_W +: DATA_W]),
            .clear_in    (bus.clear_in),
            .kill_in     (kill),
            .shift_en    (shift_en),
            .shift_in    (acc_chain[k]),
            .acc_out     (acc_chain[k+1]),
            .ovf_out     (pe_ovf[k])
        );
    end

    // Controller: RUN accepts samples, FLUSH lets in-flight samples land, DRAIN
    // shifts N_PE accumulators out. Clear aborts anything back to RUN.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_en = 1'b0;
        unique case (state_q)
            StRun: begin
                if (!bus.clear_in && bus.drain_in) begin
                    state_d = (|v_chain) ? StFlush : StDrain;
                end
            end
            StFlush: begin
                if (bus.clear_in) begin
                    state_d = StRun;
                end else if (!(|v_chain[N_PE-1:0])) begin
                    // The last element's register needs no further accumulate.
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (bus.clear_in) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    shift_en = 1'b1;
                    if (cnt_q == CntW'(N_PE - 1)) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Controller state, drain counter and the b pass-through register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
            cnt_q   <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= bus.b_in;
        end
    end

    assign bus.ready_out   = ready;
    assign bus.a_out       = a_chain[N_PE];
    assign bus.a_valid_out = v_chain[N_PE];
    assign bus.b_out       = b_q;
    assign bus.c_valid_out = (state_q == StDrain);
    assign bus.c_out       = (state_q == StDrain) ? acc_chain[N_PE] : '0;
    assign bus.ovf_out     = |pe_ovf;

endmodule

// File: doc/systolic_row.md
Name: systolic_row

Overview:
- Parametrised one-dimensional systolic row of N_PE output-stationary multiply-accumulate elements. It is the successor to the single 8-bit processing element.
- Operand `a` ripples left to right through one register per element. Each element takes its own `b` column operand.
- Accumulators are read out serially through a drain chain.
- `b` is passed through registered so that rows can be stacked into a 2-D array.

Parameters:
DATA_W, 8, signed operand width
ACC_W, 24, signed accumulator width (must be >= 2*DATA_W)
N_PE, 4, number of elements in the row (>= 2)

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low; 0 resets all state immediately
clear_in  in  1  zero all accumulators and the overflow flag
a_valid_in  in  1  a_in carries a sample this cycle
a_in  in  DATA_W  signed operand entering element 0
b_in  in  N_PE*DATA_W  slice k = signed column operand for element k
drain_in  in  1  request accumulator readout
ready_out  out  1  1 = a_valid_in is accepted this cycle
a_out  out  DATA_W  a register of element N_PE-1, for chaining
a_valid_out  out  1  valid paired with a_out
b_out  out  N_PE*DATA_W  b_in registered one cycle, for the row below
c_out  out  ACC_W  drained accumulator value
c_valid_out  out  1  c_out is valid this cycle
ovf_out  out  1  sticky signed accumulate overflow in any element

Behaviour:
Reset (reset=0):
- All a/valid/b registers, accumulators, c_out, c_valid_out and ovf_out go to 0.
- FSM goes to RUN and ready_out=1.
- Reset takes effect asynchronously, mid-drain included.

Datapath:
- Element k operand input: a_in/accepted-valid for k=0, otherwise element k-1's a register/valid.
- On each edge with the operand valid set: acc_k <= acc_k + sext(a_k * b_in[k]), then a register k <= operand.
- Product is full 2*DATA_W signed, sign-extended to ACC_W.
- Accumulation wraps modulo 2^ACC_W.
- Signed overflow (operand signs equal, result sign differs) sets ovf_out. It stays set until clear_in or reset.
- Sample accepted in cycle t is accumulated in element k at the end of cycle t+k. The driver presents b_in slice k in cycle t+k; skew is the driver's responsibility.
- a_out/a_valid_out lag a_in by N_PE cycles. b_out lags b_in by 1 cycle regardless of FSM state.

FSM states:
- RUN:
  - ready_out=1.
  - drain_in with any valid in the element registers -> FLUSH.
  - drain_in with the pipeline empty -> DRAIN.
- FLUSH:
  - ready_out=0 and a_valid_in is ignored; in-flight samples keep accumulating.
  - When no valid bit remains in elements 0..N_PE-2 and no operand valid is pending -> DRAIN.
- DRAIN:
  - ready_out=0.
  - Accumulators form a shift chain toward element N_PE-1.
  - For N_PE consecutive cycles: c_out = acc of element N_PE-1, then N_PE-2, ... down to 0, with c_valid_out=1. Shift-in value is 0.
  - After the last value -> RUN, with all accumulators at 0.
  - drain_in during FLUSH/DRAIN is ignored.

Boundary and priority rules:
- clear_in and an accumulate in the same cycle: clear wins for the old value; acc <= product (accumulation restarts).
- clear_in during FLUSH/DRAIN: aborts the readout, zeroes accumulators and the in-flight valid bits, c_valid_out=0 next cycle, returns to RUN.
- clear_in does not clear ovf_out if the same-cycle product overflows, which is impossible since ACC_W >= 2*DATA_W.
- drain_in and clear_in together: clear has priority and drain is dropped.
- a_valid_in while ready_out=0: the sample is dropped and no state changes.

Decomposition:
- Shared package constants: FSM state encodings (RUN, FLUSH, DRAIN), default widths, and a sign-extension/overflow helper function.
- Sub-module systolic_pe (one element):
  - Ports: clock, reset, operand a/valid in and out, b, clear, shift_en, shift_in, acc out, ovf out.
  - Instantiated N_PE times via generate.
- FSM, flush detection and output muxing stay in systolic_row.

Test Plan (N_PE=4, DATA_W=8, ACC_W=24 unless noted):
1. Reset: hold reset=0 with random inputs -> all outputs 0 and ready_out=0 only after release? No: ready_out=1 after release. Pulse reset=0 mid-DRAIN -> c_valid_out drops to 0 immediately.
2. Dot product: a=1,2,3 on consecutive cycles with b slice k=2 skewed by k, then drain_in -> FLUSH, then 4 cycles of c_out=12 with c_valid_out=1, then ready_out=1 and a second drain yields 0,0,0,0.
3. Signed extremes: a=-128 with b=-128 at element 0, and a=-1 with b=127 at element 3 -> element 0 drains 16384 and element 3 drains -127. Drain order is element 3 first.
4. Overflow (ACC_W=16): three accumulates of 127*127=16129 in element 1 -> after the third, acc wraps to -17149 and ovf_out=1; clear_in -> ovf_out=0.
5. Backpressure and simultaneity:
   - a_valid_in asserted during FLUSH -> not accumulated (drained totals unchanged).
   - clear_in together with a valid 5*3 -> acc=15.
6. Abort: clear_in on the 2nd DRAIN cycle -> c_valid_out=0 next cycle, RUN entered, subsequent drain yields all zeros.
